// File: rtl/bigadd_sched.sv
// Time-multiplexed N-bit adder: two-requester round-robin front end, one shared W-bit slice adder.
// Define BIGADD_SCHED_COUT_EN to add the res_cout port (carry out of bit N-1).
module bigadd_sched #(
    parameter int N = 1024,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_sum,
    output logic         res_id,
`ifdef BIGADD_SCHED_COUT_EN
    output logic         res_cout,
`endif
    output logic         busy
);

    localparam int C  = (N + W - 1) / W;
    localparam int TW = C * W;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   a_q, a_d;
    logic [TW-1:0]   b_q, b_d;
    logic [TW-1:0]   res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            id_q, id_d;
    logic            last_grant_q, last_grant_d;
    logic            grant0, grant1;
    logic [W:0]      slice_sum;
`ifdef BIGADD_SCHED_COUT_EN
    // Width of the last (possibly partial) slice; its carry sits at bit LAST of slice_sum.
    localparam int LAST = N - (C - 1) * W;
    logic            cout_q, cout_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
`ifdef BIGADD_SCHED_COUT_EN
            cout_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
`ifdef BIGADD_SCHED_COUT_EN
            cout_q       <= cout_d;
`endif
        end
    end

    // Operands shift down one slice per ADD cycle so the slice adder always reads bits [W-1:0];
    // results enter at the top and land in slice order after C cycles.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        grant0       = 1'b0;
        grant1       = 1'b0;
`ifdef BIGADD_SCHED_COUT_EN
        cout_d       = cout_q;
`endif
        slice_sum = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + {{W{1'b0}}, carry_q};

        unique case (state_q)
            IDLE: begin
                grant0 = reset_n & req0_valid & (~req1_valid | last_grant_q);
                grant1 = reset_n & req1_valid & (~req0_valid | ~last_grant_q);
                if (grant0 || grant1) begin
                    a_d = '0;
                    b_d = '0;
                    if (grant1) begin
                        a_d[N-1:0] = req1_a;
                        b_d[N-1:0] = req1_b;
                    end else begin
                        a_d[N-1:0] = req0_a;
                        b_d[N-1:0] = req0_b;
                    end
                    id_d         = grant1;
                    last_grant_d = grant1;
                    carry_d      = 1'b0;
                    cnt_d        = '0;
                    state_d      = ADD;
                end
            end
            ADD: begin
                a_d              = a_q >> W;
                b_d              = b_q >> W;
                res_d            = res_q >> W;
                res_d[TW-1 -: W] = slice_sum[W-1:0];
                carry_d          = slice_sum[W];
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == CW'(C - 1)) begin
                    state_d = DONE;
`ifdef BIGADD_SCHED_COUT_EN
                    cout_d  = slice_sum[LAST];
`endif
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = (state_q == DONE);
    assign res_sum    = res_q[N-1:0];
    assign res_id     = id_q;
    assign busy       = (state_q != IDLE);
`ifdef BIGADD_SCHED_COUT_EN
    assign res_cout   = cout_q;
`endif

endmodule

// File: tb/tb_bigadd_sched.sv
// Directed self-checking bench for bigadd_sched: N=64/W=32 main instance plus an N=40/W=32 partial-slice instance.
module tb_bigadd_sched;

    localparam int N  = 64;
    localparam int W  = 32;
    localparam int NP = 40;

    logic          clk;
    logic          reset_n;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          res_valid, res_ready, res_id, busy;
    logic [N-1:0]  res_sum;

    logic          p_req0_valid, p_req1_valid, p_req0_ready, p_req1_ready;
    logic [NP-1:0] p_req0_a, p_req0_b, p_req1_a, p_req1_b;
    logic          p_res_valid, p_res_ready, p_res_id, p_busy;
    logic [NP-1:0] p_res_sum;

`ifdef BIGADD_SCHED_COUT_EN
    logic          res_cout, p_res_cout;
`endif

    int total = 0;
    int bad   = 0;
    int cycles;

    bigadd_sched #(.N(N), .W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_id     (res_id),
`ifdef BIGADD_SCHED_COUT_EN
        .res_cout   (res_cout),
`endif
        .busy       (busy)
    );

    bigadd_sched #(.N(NP), .W(W)) dut_p (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (p_req0_valid),
        .req0_ready (p_req0_ready),
        .req0_a     (p_req0_a),
        .req0_b     (p_req0_b),
        .req1_valid (p_req1_valid),
        .req1_ready (p_req1_ready),
        .req1_a     (p_req1_a),
        .req1_b     (p_req1_b),
        .res_valid  (p_res_valid),
        .res_ready  (p_res_ready),
        .res_sum    (p_res_sum),
        .res_id     (p_res_id),
`ifdef BIGADD_SCHED_COUT_EN
        .res_cout   (p_res_cout),
`endif
        .busy       (p_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                                 input logic v1, input logic [N-1:0] a1, input logic [N-1:0] b1);
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
    endtask

    // Ticks until the selected instance raises res_valid, giving up after 20 cycles.
    task automatic waitResult(input bit partial, output int n);
        n = 0;
        while (!(partial ? p_res_valid : res_valid) && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        res_ready    = 1'b0;
        applyStimulus(1'b1, 64'd0, 64'd0, 1'b1, 64'd0, 64'd0);
        p_req0_valid = 1'b0;
        p_req1_valid = 1'b0;
        p_req0_a     = '0;
        p_req0_b     = '0;
        p_req1_a     = '0;
        p_req1_b     = '0;
        p_res_ready  = 1'b1;

        #1;
        checkOutput("rst_busy",   busy,       1'b0);
        checkOutput("rst_valid",  res_valid,  1'b0);
        checkOutput("rst_sum",    res_sum,    64'd0);
        checkOutput("rst_id",     res_id,     1'b0);
        checkOutput("rst_ready0", req0_ready, 1'b0);
        checkOutput("rst_ready1", req1_ready, 1'b0);
        tick();
        tick();

        // Single request with a carry crossing the slice boundary.
        reset_n = 1'b1;
        applyStimulus(1'b1, 64'h0000_0001_FFFF_FFFF, 64'h1, 1'b0, 64'd0, 64'd0);
        #1;
        checkOutput("t1_ready0", req0_ready, 1'b1);
        checkOutput("t1_ready1", req1_ready, 1'b0);
        tick();
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
        checkOutput("t1_busy", busy, 1'b1);
        checkOutput("t1_nvalid", res_valid, 1'b0);
        waitResult(1'b0, cycles);
        checkOutput("t1_latency", cycles, 2);
        checkOutput("t1_sum", res_sum, 64'h0000_0002_0000_0000);
        checkOutput("t1_id", res_id, 1'b0);
`ifdef BIGADD_SCHED_COUT_EN
        checkOutput("t1_cout", res_cout, 1'b0);
`endif
        res_ready = 1'b1;
        tick();
        checkOutput("t1_idle_valid", res_valid, 1'b0);
        checkOutput("t1_idle_busy", busy, 1'b0);

        // Full ripple and truncation from requester 1.
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        #1;
        checkOutput("t2_ready1", req1_ready, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
        waitResult(1'b0, cycles);
        checkOutput("t2_latency", cycles, 2);
        checkOutput("t2_sum", res_sum, 64'd0);
        checkOutput("t2_id", res_id, 1'b1);
`ifdef BIGADD_SCHED_COUT_EN
        checkOutput("t2_cout", res_cout, 1'b1);
`endif
        tick();

        // Contention straight out of reset: grants must alternate starting with requester 0.
        reset_n = 1'b0;
        applyStimulus(1'b1, 64'd10, 64'd20, 1'b1, 64'd100, 64'd200);
        #1;
        checkOutput("t3_rst_ready0", req0_ready, 1'b0);
        checkOutput("t3_rst_ready1", req1_ready, 1'b0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("t3_grant0", req0_ready, (i % 2) == 0);
            checkOutput("t3_grant1", req1_ready, (i % 2) == 1);
            tick();
            waitResult(1'b0, cycles);
            checkOutput("t3_latency", cycles, 2);
            checkOutput("t3_id", res_id, (i % 2) == 1);
            checkOutput("t3_sum", res_sum, ((i % 2) == 1) ? 64'd300 : 64'd30);
            checkOutput("t3_done_ready0", req0_ready, 1'b0);
            checkOutput("t3_done_ready1", req1_ready, 1'b0);
            tick();
        end

        // Backpressure: result held while both requesters wait.
        res_ready = 1'b0;
        applyStimulus(1'b1, 64'd5, 64'd7, 1'b0, 64'd1, 64'd2);
        tick();
        applyStimulus(1'b1, 64'd5, 64'd7, 1'b1, 64'd1, 64'd2);
        waitResult(1'b0, cycles);
        checkOutput("t4_latency", cycles, 2);
        for (int j = 0; j < 5; j++) begin
            checkOutput("t4_hold_valid", res_valid, 1'b1);
            checkOutput("t4_hold_sum", res_sum, 64'd12);
            checkOutput("t4_hold_id", res_id, 1'b0);
            checkOutput("t4_hold_ready0", req0_ready, 1'b0);
            checkOutput("t4_hold_ready1", req1_ready, 1'b0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        checkOutput("t4_release_ready1", req1_ready, 1'b0);
        tick();
        checkOutput("t4_idle_valid", res_valid, 1'b0);
        checkOutput("t4_next_ready1", req1_ready, 1'b1);
        checkOutput("t4_next_ready0", req0_ready, 1'b0);
        tick();
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
        waitResult(1'b0, cycles);
        checkOutput("t4b_sum", res_sum, 64'd3);
        checkOutput("t4b_id", res_id, 1'b1);
        tick();

        // Reset during ADD slice 0 abandons the request.
        applyStimulus(1'b1, 64'd3, 64'd4, 1'b0, 64'd0, 64'd0);
        tick();
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
        checkOutput("t5_busy_add", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_busy", busy, 1'b0);
        checkOutput("t5_rst_valid", res_valid, 1'b0);
        checkOutput("t5_rst_sum", res_sum, 64'd0);
        checkOutput("t5_rst_id", res_id, 1'b0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t5_no_result", res_valid, 1'b0);
        end
        applyStimulus(1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 64'd9, 64'd9);
        #1;
        checkOutput("t5_grant0", req0_ready, 1'b1);
        checkOutput("t5_grant1", req1_ready, 1'b0);
        tick();
        applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0);
        waitResult(1'b0, cycles);
        checkOutput("t5_latency", cycles, 2);
        checkOutput("t5_sum", res_sum, 64'h0000_0001_FFFF_FFFE);
        checkOutput("t5_id", res_id, 1'b0);
        tick();

        // Partial last slice on the N=40 instance.
        p_req0_valid = 1'b1;
        p_req0_a     = 40'hFF_FFFF_FFFF;
        p_req0_b     = 40'h1;
        #1;
        checkOutput("t6_ready0", p_req0_ready, 1'b1);
        tick();
        p_req0_valid = 1'b0;
        waitResult(1'b1, cycles);
        checkOutput("t6_latency", cycles, 2);
        checkOutput("t6_sum", p_res_sum, 40'h0);
`ifdef BIGADD_SCHED_COUT_EN
        checkOutput("t6_cout", p_res_cout, 1'b1);
`endif
        tick();
        p_req0_valid = 1'b1;
        p_req0_a     = 40'h7F_FFFF_FFFF;
        p_req0_b     = 40'h1;
        tick();
        p_req0_valid = 1'b0;
        waitResult(1'b1, cycles);
        checkOutput("t6b_sum", p_res_sum, 40'h80_0000_0000);
        checkOutput("t6b_id", p_res_id, 1'b0);
`ifdef BIGADD_SCHED_COUT_EN
        checkOutput("t6b_cout", p_res_cout, 1'b0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bigadd_sched.md
Name: bigadd_sched

Overview:
- Time-multiplexed wide adder with a two-requester round-robin front end.
- Each granted N-bit add request is captured, then summed one W-bit slice per cycle through a single shared slice adder, with a registered carry between slices.
- Used wherever a full-width carry-select add is too costly in area, e.g. accumulation/reduction paths that can tolerate multi-cycle latency.
- Result is truncated to N bits, as in the combinational wide adder.

Parameters:
- N, 1024, operand/result width in bits (>= 1).
- W, 32, slice width of the shared adder in bits (1..N).
- C (localparam), ceil(N/W), number of slice cycles per add.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous assert, active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  N  requester 0 operand A.
- req0_b  in  N  requester 0 operand B.
- req1_valid  in  1  requester 1 has an operand pair.
- req1_ready  out  1  requester 1 accepted this cycle.
- req1_a  in  N  requester 1 operand A.
- req1_b  in  N  requester 1 operand B.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_sum  out  N  (A+B) mod 2^N.
- res_id  out  1  index of requester that owns res_sum.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (reset_n low, asynchronous): state=IDLE, req0_ready=0, req1_ready=0, res_valid=0, res_sum=0, res_id=0, busy=0, carry=0, slice counter=0, last_grant=1 (req0 wins first contention).
- States: IDLE -> ADD -> DONE -> IDLE.
- IDLE:
  - reqX_ready is combinational from reqX_valid and arbitration.
  - At most one ready is high, and only in IDLE.
  - Transfer = valid & ready in the same cycle.
  - On transfer: capture A/B (zero-padded to C*W bits), record id, set last_grant=id, clear carry and counter, go to ADD.
- Arbitration: if only one valid, grant it. If both valid, grant the requester != last_grant.
- ADD: each cycle, slice k = counter:
  - sum_k = A[k] + B[k] + carry.
  - Write sum_k into result slice k; carry <= bit W of the slice sum; counter increments.
  - After slice C-1, go to DONE.
- DONE:
  - res_valid=1; res_sum and res_id stay stable until res_ready is sampled high.
  - On res_valid & res_ready: res_valid <= 0, go to IDLE.
  - A new request cannot be accepted in that same cycle (earliest acceptance is the following cycle).
- Latency: transfer in cycle T gives res_valid high from cycle T+C+1.
- Throughput: one add per C+2 cycles when the consumer is always ready.
- Inputs after transfer: changes on reqX_a/b after the transfer cycle are ignored. A valid that is not accepted must be held by the requester; there is no drop or timeout.
- Width rules:
  - Final carry out of bit N-1 is discarded.
  - Pad bits of the last partial slice (N not a multiple of W) are zero and never appear on res_sum.
- Boundary cases:
  - C=1 (W>=N): one ADD cycle.
  - All-ones plus one: carry ripples through every slice and gives 0.
  - res_ready high before res_valid has no effect.
- Reset mid-operation: any state returns to IDLE immediately, the in-flight request is abandoned, and no result is produced. last_grant returns to 1.

Optional Feature:
- Macro: BIGADD_SCHED_COUT_EN.
- When defined:
  - Adds output port res_cout (1 bit) = carry out of bit N-1 of the full A+B.
  - For a partial last slice, res_cout is taken from bit N-1's carry, not bit W of the padded slice.
  - res_cout is valid and stable with res_valid; reset value 0.
- When undefined: port absent, final carry discarded, no other change in behaviour or timing.

Test Plan (N=64, W=32, C=2 unless noted):
- Single request: req0 A=0x0000_0001_FFFF_FFFF, B=0x1 accepted at cycle T -> res_valid at T+3, res_sum=0x0000_0002_0000_0000, res_id=0.
- Full ripple/truncation: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> res_sum=0; with BIGADD_SCHED_COUT_EN, res_cout=1.
- Contention after reset: req0 and req1 both valid at reset release -> req0 granted first, then req1. If both are held valid, grants alternate 0,1,0,1 and res_id follows the same order.
- Backpressure: res_ready held low for 5 cycles after res_valid -> res_sum/res_id stable, req0_ready/req1_ready stay 0; res_ready=1 -> next request accepted on the following cycle.
- Reset mid-add: reset_n pulsed low during ADD slice 0 -> outputs return to reset values immediately, no res_valid, next request returns a correct sum.
- Partial slice: N=40, W=32, A=0xFF_FFFF_FFFF, B=0x1 -> res_sum=0 after C=2 slices; with BIGADD_SCHED_COUT_EN, res_cout=1.
